fifo_empty_block: RTL and testbench

//  Read-side pointer/flag block of the dual-clock gray-pointer FIFO; pairs with the write-side full block.

---
 rtl/fifo_empty_block_pkg.sv | 13 +
 rtl/fifo_empty_block_if.sv | 22 ++
 rtl/fifo_empty_block_sync.sv | 30 +++
 rtl/fifo_empty_block.sv | 100 ++++++++++
 tb/tb_fifo_empty_block.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_empty_block_pkg.sv
// Shared definitions for the read-side pointer/flag block of the dual-clock gray-pointer FIFO.
package fifo_empty_block_pkg;

    localparam int FIFO_AW_DEF          = 2;
    localparam int FIFO_SYNC_STAGES_DEF = 2;
    localparam int FIFO_AE_THRESH_DEF   = 1;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int fifo_ptr_w(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/fifo_empty_block_if.sv
// Read-side FIFO bus: raw write gray pointer and pop request in, flags and pointers out.
interface fifo_empty_block_if #(
    parameter int AW = 2
);
    logic [AW:0]   wr_gray_pointer;
    logic          rd_read;
    logic          rd_fifo_empty;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   rd_gray_pointer;
    logic [AW:0]   rd_fifo_level;
    logic          rd_fifo_almost_empty;

    modport master (
        output wr_gray_pointer, rd_read,
        input  rd_fifo_empty, rd_addr, rd_gray_pointer, rd_fifo_level, rd_fifo_almost_empty
    );

    modport slave (
        input  wr_gray_pointer, rd_read,
        output rd_fifo_empty, rd_addr, rd_gray_pointer, rd_fifo_level, rd_fifo_almost_empty
    );
endinterface

// File: rtl/fifo_empty_block_sync.sv
// Plain flop chain bringing the write gray pointer into the read clock domain.
module fifo_gray_sync #(
    parameter int DW          = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic          rd_clk,
    input  logic          reset,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] sync_r [SYNC_STAGES];

    // Synchronizer shift chain; no logic between stages.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {DW{1'b0}};
            end
        end else begin
            sync_r[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign dout = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_empty_block.sv
// Read-side pointers and registered empty flag of the gray-pointer FIFO.
// Define FIFO_RD_LEVEL_EN to add the registered occupancy level and almost-empty flag.
module fifo_empty_block
    import fifo_empty_block_pkg::*;
#(
    parameter int AW          = FIFO_AW_DEF,
    parameter int SYNC_STAGES = FIFO_SYNC_STAGES_DEF,
    parameter int AE_THRESH   = FIFO_AE_THRESH_DEF
) (
    input  logic               rd_clk,
    input  logic               reset,
    fifo_empty_block_if.slave  rd_if
);

    localparam int PW = fifo_ptr_w(AW);

    logic [PW-1:0] rd_binary_r;
    logic [PW-1:0] rd_gray_r;
    logic          rd_fifo_empty_r;
    logic [PW-1:0] rd_binary_next_s;
    logic [PW-1:0] rd_gray_next_s;
    logic [PW-1:0] rd_wr_gray_sync_s;
    logic          rd_read_ok_s;

    fifo_gray_sync #(
        .DW          (PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .rd_clk (rd_clk),
        .reset  (reset),
        .din    (rd_if.wr_gray_pointer),
        .dout   (rd_wr_gray_sync_s)
    );

    // Next read pointer; a pop while empty is dropped.
    always_comb begin
        rd_read_ok_s     = rd_if.rd_read & ~rd_fifo_empty_r;
        rd_binary_next_s = rd_binary_r + {{(PW-1){1'b0}}, rd_read_ok_s};
        rd_gray_next_s   = (rd_binary_next_s >> 1) ^ rd_binary_next_s;
    end

    // Pointer registers and empty flag; empty is judged against the next pointer so the last pop flags at once.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            rd_binary_r     <= {PW{1'b0}};
            rd_gray_r       <= {PW{1'b0}};
            rd_fifo_empty_r <= 1'b1;
        end else begin
            rd_binary_r     <= rd_binary_next_s;
            rd_gray_r       <= rd_gray_next_s;
            rd_fifo_empty_r <= (rd_gray_next_s == rd_wr_gray_sync_s);
        end
    end

    assign rd_if.rd_fifo_empty   = rd_fifo_empty_r;
    assign rd_if.rd_addr         = rd_binary_r[AW-1:0];
    assign rd_if.rd_gray_pointer = rd_gray_r;

`ifdef FIFO_RD_LEVEL_EN
    localparam logic [PW-1:0] AE_THRESH_W = AE_THRESH[PW-1:0];

    logic [PW-1:0] wr_bin_sync_s;
    logic [PW-1:0] level_next_s;
    logic [PW-1:0] rd_fifo_level_r;
    logic          rd_fifo_almost_empty_r;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // A stale synced write pointer can only under-report the level.
    always_comb begin
        wr_bin_sync_s = gray2bin(rd_wr_gray_sync_s);
        level_next_s  = wr_bin_sync_s - rd_binary_next_s;
    end

    // Level and almost-empty registered on the same edge as the empty flag.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            rd_fifo_level_r        <= {PW{1'b0}};
            rd_fifo_almost_empty_r <= 1'b1;
        end else begin
            rd_fifo_level_r        <= level_next_s;
            rd_fifo_almost_empty_r <= (level_next_s <= AE_THRESH_W);
        end
    end

    assign rd_if.rd_fifo_level        = rd_fifo_level_r;
    assign rd_if.rd_fifo_almost_empty = rd_fifo_almost_empty_r;
`else
    assign rd_if.rd_fifo_level        = {PW{1'b0}};
    assign rd_if.rd_fifo_almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_empty_block.sv
// Scoreboard bench for fifo_empty_block (AW=2, SYNC_STAGES=2, AE_THRESH=1).
module tb_fifo_empty_block;

    logic rd_clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        int         due;
        string      name;
        logic [9:0] val;
    } exp_t;

    exp_t q[$];

    fifo_empty_block_if #(.AW(2)) bus ();

    fifo_empty_block #(
        .AW          (2),
        .SYNC_STAGES (2),
        .AE_THRESH   (1)
    ) dut (
        .rd_clk (rd_clk),
        .reset  (reset),
        .rd_if  (bus)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    // Expected state after the edge just taken: {empty, addr, gray, level, almost_empty}.
    task automatic expect_now(input string nm, input logic e, input logic [1:0] a,
                              input logic [2:0] g, input logic [2:0] lvl);
        exp_t       x;
        logic [2:0] lvl_e;
        logic       ae_e;
`ifdef FIFO_RD_LEVEL_EN
        lvl_e = lvl;
        ae_e  = (lvl <= 3'd1);
`else
        lvl_e = 3'd0;
        ae_e  = 1'b0;
`endif
        x.due  = cyc;
        x.name = nm;
        x.val  = {e, a, g, lvl_e, ae_e};
        q.push_back(x);
    endtask

    task automatic do_reset();
        reset               = 1'b1;
        bus.wr_gray_pointer = 3'b000;
        bus.rd_read         = 1'b0;
        tick();
        expect_now("reset_pulse", 1'b1, 2'd0, 3'b000, 3'd0);
        reset = 1'b0;
    endtask

    // Monitor: compare every expectation that falls due on this cycle.
    always @(negedge rd_clk) begin
        logic [9:0] act;
        act = {bus.rd_fifo_empty, bus.rd_addr, bus.rd_gray_pointer,
               bus.rd_fifo_level, bus.rd_fifo_almost_empty};
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
                n_checks++;
                if (act !== q[i].val) begin
                    n_fail++;
                    $display("FAIL %s (cycle %0d): {empty,addr,gray,level,ae} got %b required %b",
                             q[i].name, cyc, act, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    logic [2:0] gray_tbl [8];
    logic [2:0] prev_g;
    logic [1:0] addr_after;

    initial begin
        gray_tbl[0] = 3'b001; gray_tbl[1] = 3'b011; gray_tbl[2] = 3'b010; gray_tbl[3] = 3'b110;
        gray_tbl[4] = 3'b111; gray_tbl[5] = 3'b101; gray_tbl[6] = 3'b100; gray_tbl[7] = 3'b000;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;

        reset               = 1'b1;
        bus.wr_gray_pointer = 3'b000;
        bus.rd_read         = 1'b0;
        tick();
        tick();
        expect_now("reset", 1'b1, 2'd0, 3'b000, 3'd0);
        n_checks++;
        if (bus.rd_fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_direct: empty got %b required 1", bus.rd_fifo_empty);
        end
        reset = 1'b0;

        bus.rd_read = 1'b1;
        repeat (5) begin
            tick();
            expect_now("read_while_empty", 1'b1, 2'd0, 3'b000, 3'd0);
        end
        bus.rd_read = 1'b0;

        bus.wr_gray_pointer = 3'b001;
        tick(); expect_now("wr_sync_edge1", 1'b1, 2'd0, 3'b000, 3'd0);
        tick(); expect_now("wr_sync_edge2", 1'b1, 2'd0, 3'b000, 3'd0);
        tick(); expect_now("wr_visible_edge3", 1'b0, 2'd0, 3'b000, 3'd1);
        bus.rd_read = 1'b1;
        tick(); expect_now("pop_last_empty", 1'b1, 2'd1, 3'b001, 3'd0);
        bus.rd_read = 1'b0;

        do_reset();
        bus.wr_gray_pointer = 3'b110;
        tick(); expect_now("four_edge1", 1'b1, 2'd0, 3'b000, 3'd0);
        tick(); expect_now("four_edge2", 1'b1, 2'd0, 3'b000, 3'd0);
        tick(); expect_now("four_visible", 1'b0, 2'd0, 3'b000, 3'd4);
        bus.rd_read = 1'b1;
        tick(); expect_now("pop1", 1'b0, 2'd1, 3'b001, 3'd3);
        tick(); expect_now("pop2", 1'b0, 2'd2, 3'b011, 3'd2);
        tick(); expect_now("pop3_almost", 1'b0, 2'd3, 3'b010, 3'd1);
        tick(); expect_now("pop4_empty", 1'b1, 2'd0, 3'b110, 3'd0);
        n_checks++;
        if (bus.rd_gray_pointer !== 3'b110) begin
            n_fail++;
            $display("FAIL pop4_direct: rd_gray got %b required 110", bus.rd_gray_pointer);
        end
        bus.rd_read = 1'b0;

        do_reset();
        for (int k = 0; k < 8; k++) begin
            prev_g     = (k == 0) ? 3'b000 : gray_tbl[k-1];
            addr_after = 2'(k + 1);
            bus.wr_gray_pointer = gray_tbl[k];
            repeat (3) tick();
            expect_now("wrap_avail", 1'b0, 2'(k), prev_g, 3'd1);
            bus.rd_read = 1'b1;
            tick();
            expect_now("wrap_pop", 1'b1, addr_after, gray_tbl[k], 3'd0);
            bus.rd_read = 1'b0;
        end
        n_checks++;
        if (bus.rd_fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_final_empty: empty got %b required 1", bus.rd_fifo_empty);
        end
        n_checks++;
        if (bus.rd_gray_pointer !== 3'b000) begin
            n_fail++;
            $display("FAIL wrap_final_gray: rd_gray got %b required 000", bus.rd_gray_pointer);
        end

        do_reset();
        bus.wr_gray_pointer = 3'b010;
        repeat (3) tick();
        expect_now("level3", 1'b0, 2'd0, 3'b000, 3'd3);
        reset               = 1'b1;
        bus.rd_read         = 1'b1;
        bus.wr_gray_pointer = 3'b000;
        tick();
        expect_now("reset_beats_read", 1'b1, 2'd0, 3'b000, 3'd0);
        n_checks++;
        if (bus.rd_addr !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_beats_read_direct: rd_addr got %0d required 0", bus.rd_addr);
        end
        reset       = 1'b0;
        bus.rd_read = 1'b0;
        tick();
        expect_now("after_reset", 1'b1, 2'd0, 3'b000, 3'd0);

        repeat (4) @(negedge rd_clk);
        #1;
        while (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: never compared, due cycle %0d required %b", q[0].name, q[0].due, q[0].val);
            void'(q.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
